// File: rtl/fetch_sequencer.sv
// Multi-cycle FETCH -> DECODE -> EXEC sequencer for the 8-bit core.
// Assembles a 32-bit instruction from byte reads, drives the decoder handshake, and owns the PC.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_IDLE   | parked, waiting for run
// S_FETCH  | reading instruction bytes at pc + byte_cnt
// S_DECODE | dec_en high, waiting for the decoder's registered ready
// S_EXEC   | execute running (exec_start in first cycle), PC update on exec_done
module fetch_sequencer #(
   parameter int                   M_WIDTH    = 8,
   parameter int                   INST_WIDTH = 32,
   parameter int                   PC_WIDTH   = 8,
   parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   run,
   output logic [PC_WIDTH-1:0]    mem_addr,
   output logic                   mem_req,
   input  logic                   mem_ack,
   input  logic [M_WIDTH-1:0]     mem_rdata,
   output logic [INST_WIDTH-1:0]  inst,
   output logic                   dec_en,
   input  logic                   dec_ready,
   output logic                   exec_start,
   input  logic                   exec_done,
   input  logic                   pc_load,
   input  logic [PC_WIDTH-1:0]    pc_target,
   output logic [PC_WIDTH-1:0]    pc,
   output logic                   busy
);

   localparam int                  NBYTES    = INST_WIDTH / M_WIDTH;
   localparam int                  CNT_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [CNT_W-1:0]    LAST_BYTE = CNT_W'(NBYTES - 1);
   localparam logic [PC_WIDTH-1:0] PC_STEP   = PC_WIDTH'(NBYTES);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC
   } state_t;

   state_t                          state_q, state_d;
   logic [PC_WIDTH-1:0]             pc_q, pc_d;
   logic [INST_WIDTH-1:0]           inst_q, inst_d;
   logic [NBYTES-1:0][M_WIDTH-1:0]  shadow_q, shadow_d;
   logic [CNT_W-1:0]                byte_cnt_q, byte_cnt_d;
   logic                            exec_start_q, exec_start_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         pc_q         <= RESET_PC;
         inst_q       <= '0;
         shadow_q     <= '0;
         byte_cnt_q   <= '0;
         exec_start_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         inst_q       <= inst_d;
         shadow_q     <= shadow_d;
         byte_cnt_q   <= byte_cnt_d;
         exec_start_q <= exec_start_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      inst_d       = inst_q;
      shadow_d     = shadow_q;
      byte_cnt_d   = byte_cnt_q;
      exec_start_d = 1'b0;
      mem_req      = 1'b0;
      dec_en       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d    = S_FETCH;
               byte_cnt_d = '0;
            end
         end

         S_FETCH: begin
            mem_req = 1'b1;
            if (mem_ack) begin
               shadow_d[byte_cnt_q] = mem_rdata;
               // inst only changes here, with the last byte merged in, so the decoder never sees a partial word
               if (byte_cnt_q == LAST_BYTE) begin
                  inst_d     = shadow_d;
                  byte_cnt_d = '0;
                  state_d    = S_DECODE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
               end
            end
         end

         S_DECODE: begin
            dec_en = 1'b1;
            if (dec_ready) begin
               state_d      = S_EXEC;
               exec_start_d = 1'b1;
            end
         end

         S_EXEC: begin
            if (exec_done) begin
               pc_d    = pc_load ? pc_target : pc_q + PC_STEP;
               state_d = run ? S_FETCH : S_IDLE;
            end
         end

         default: state_d = S_IDLE;
      endcase
   end

   assign mem_addr   = pc_q + PC_WIDTH'(byte_cnt_q);
   assign inst       = inst_q;
   assign exec_start = exec_start_q;
   assign pc         = pc_q;
   assign busy       = (state_q != S_IDLE);

endmodule
